// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one upstream word port fanned out to N
// downstream channel ports, plus the dropped-word counter.
interface demux_stream_if #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  parameter int SW    = 2
);
  logic [WIDTH-1:0]   in_data;
  logic [SW-1:0]      in_sel;
  logic               in_bcast;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [7:0]         err_cnt;

  // master drives words in and consumes channels; slave is the demux itself
  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_cnt
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_cnt
  );
endinterface

// File: rtl/demux_stream.sv
// Routes each accepted word to one channel (or all channels on broadcast)
// through a one-entry holding register per channel; bad selects are counted.
module demux_stream #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  parameter int SW    = 2
) (
  input logic           clk,
  input logic           rst_n,
  demux_stream_if.slave bus
);
  localparam int          NSEL  = 1 << SW;
  localparam logic [SW:0] N_LIM = (SW + 1)'(N);

  if (SW < 1 || NSEL < N || N < 2 || N > 16) begin : g_bad_params
    $error("demux_stream: parameters need 2 <= N <= 16 and 2**SW >= N");
  end

  genvar gi;

  logic [N-1:0]    free;
  logic [NSEL-1:0] free_ext;
  logic            sel_ok;
  logic            rdy;
  logic            accept;
  logic [7:0]      err_reg;
  logic [7:0]      err_next;

  assign sel_ok = ({1'b0, bus.in_sel} < N_LIM);

  // Pad the free vector to the full select range so in_sel can index it directly
  for (gi = 0; gi < NSEL; gi++) begin : g_free_ext
    if (gi < N) begin : g_real
      assign free_ext[gi] = free[gi];
    end else begin : g_pad
      assign free_ext[gi] = 1'b0;
    end
  end

  always_comb begin
    rdy = 1'b0;
    if (!rst_n) begin
      rdy = 1'b0;
    end else if (bus.in_bcast) begin
      rdy = &free;
    end else if (!sel_ok) begin
      rdy = 1'b1;
    end else begin
      rdy = free_ext[bus.in_sel];
    end
  end

  assign accept       = bus.in_valid & rdy;
  assign bus.in_ready = rdy;

  for (gi = 0; gi < N; gi++) begin : g_chan
    localparam logic [SW-1:0] CH = SW'(gi);

    logic             valid_reg;
    logic             valid_next;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             load;

    assign free[gi] = ~valid_reg | bus.out_ready[gi];
    assign load     = accept & (bus.in_bcast | (sel_ok & (bus.in_sel == CH)));

    // A load wins over a drain in the same cycle, so a full pipe has no bubble
    always_comb begin
      valid_next = valid_reg & ~bus.out_ready[gi];
      data_next  = data_reg;
      if (load) begin
        valid_next = 1'b1;
        data_next  = bus.in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= valid_next;
        data_reg  <= data_next;
      end
    end

    assign bus.out_valid[gi]                 = valid_reg;
    assign bus.out_data[gi*WIDTH +: WIDTH]   = data_reg;
  end

  always_comb begin
    err_next = err_reg;
    if (accept && !bus.in_bcast && !sel_ok && (err_reg != 8'hFF)) begin
      err_next = err_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 8'd0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign bus.err_cnt = err_reg;
endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed table, multi-cycle sequences on a 3-channel
// instance, and random traffic against a per-channel holding model.
module tb_demux_stream;
  logic clk = 1'b0;
  logic rst4_n;
  logic rst3_n;
  always #5 clk = ~clk;

  demux_stream_if #(.WIDTH(5), .N(4), .SW(2)) b4 ();
  demux_stream_if #(.WIDTH(5), .N(3), .SW(2)) b3 ();

  demux_stream #(.WIDTH(5), .N(4), .SW(2)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(b4));
  demux_stream #(.WIDTH(5), .N(3), .SW(2)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3));

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the 4-channel instance: what each channel holds and whether it is live
  logic       mv [4];
  logic [4:0] md [4];
  int         merr;
  logic       mdl_rdy;
  logic       rdy4_seen;
  logic       rdy3_seen;

  typedef struct {
    logic        r;
    logic [4:0]  d;
    logic [1:0]  s;
    logic        bc;
    logic        v;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_valid;
    logic [19:0] e_data;
    logic [7:0]  e_err;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic model_ready(input logic r, input logic [1:0] s, input logic bc,
                                       input logic [3:0] ordy);
    int nfree = 0;
    if (!r) return 1'b0;
    for (int k = 0; k < 4; k++) if (!mv[k] || ordy[k]) nfree++;
    if (bc) return (nfree == 4);
    if (int'(s) >= 4) return 1'b1;
    return (!mv[s] || ordy[s]);
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v = '0;
    for (int k = 0; k < 4; k++) v[k] = mv[k];
    return v;
  endfunction

  function automatic logic [19:0] model_data();
    logic [19:0] d = '0;
    for (int k = 0; k < 4; k++) d[k*5 +: 5] = md[k];
    return d;
  endfunction

  task automatic model_clock(input logic r, input logic [4:0] d, input logic [1:0] s,
                             input logic bc, input logic v, input logic [3:0] ordy,
                             input logic ok);
    if (!r) begin
      for (int k = 0; k < 4; k++) begin mv[k] = 1'b0; md[k] = '0; end
      merr = 0;
    end else begin
      for (int k = 0; k < 4; k++) if (mv[k] && ordy[k]) mv[k] = 1'b0;
      if (v && ok) begin
        if (bc) begin
          for (int k = 0; k < 4; k++) begin mv[k] = 1'b1; md[k] = d; end
        end else if (int'(s) < 4) begin
          mv[s] = 1'b1; md[s] = d;
        end else if (merr < 255) begin
          merr++;
        end
      end
    end
  endtask

  task automatic step4(input logic r, input logic [4:0] d, input logic [1:0] s,
                       input logic bc, input logic v, input logic [3:0] ordy);
    rst4_n = r; b4.in_data = d; b4.in_sel = s; b4.in_bcast = bc;
    b4.in_valid = v; b4.out_ready = ordy;
    @(negedge clk);
    rdy4_seen = b4.in_ready;
    mdl_rdy   = model_ready(r, s, bc, ordy);
    model_clock(r, d, s, bc, v, ordy, mdl_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic r, input logic [4:0] d, input logic [1:0] s,
                       input logic bc, input logic v, input logic [2:0] ordy);
    rst3_n = r; b3.in_data = d; b3.in_sel = s; b3.in_bcast = bc;
    b3.in_valid = v; b3.out_ready = ordy;
    @(negedge clk);
    rdy3_seen = b3.in_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_rdy;
    int bad_val;
    logic        r, bc, v;
    logic [4:0]  d;
    logic [1:0]  s;
    logic [3:0]  ordy;

    for (int k = 0; k < 4; k++) begin mv[k] = 1'b0; md[k] = '0; end
    merr = 0;
    rst4_n = 1'b0; rst3_n = 1'b0;
    b4.in_data = '0; b4.in_sel = '0; b4.in_bcast = 1'b0; b4.in_valid = 1'b0; b4.out_ready = '0;
    b3.in_data = '0; b3.in_sel = '0; b3.in_bcast = 1'b0; b3.in_valid = 1'b0; b3.out_ready = '0;

    //          r     d      s     bc    v     ordy     rdy   valid    data        err
    tbl[0]  = '{1'b0, 5'h1F, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 20'h00000, 8'd0};
    tbl[1]  = '{1'b1, 5'h07, 2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 20'h01C00, 8'd0};
    tbl[2]  = '{1'b1, 5'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 20'h01C00, 8'd0};
    tbl[3]  = '{1'b1, 5'h11, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0010, 20'h01E20, 8'd0};
    tbl[4]  = '{1'b1, 5'h12, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 4'b0010, 20'h01E20, 8'd0};
    tbl[5]  = '{1'b1, 5'h12, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 20'h01E40, 8'd0};
    tbl[6]  = '{1'b1, 5'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 20'h01E40, 8'd0};
    tbl[7]  = '{1'b1, 5'h0A, 2'd3, 1'b0, 1'b1, 4'b0111, 1'b1, 4'b1000, 20'h51E40, 8'd0};
    tbl[8]  = '{1'b1, 5'h1F, 2'd0, 1'b1, 1'b1, 4'b0111, 1'b0, 4'b1000, 20'h51E40, 8'd0};
    tbl[9]  = '{1'b1, 5'h1F, 2'd0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 20'hFFFFF, 8'd0};
    tbl[10] = '{1'b1, 5'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 20'hFFFFF, 8'd0};
    tbl[11] = '{1'b1, 5'h03, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, 20'hFFFE3, 8'd0};
    tbl[12] = '{1'b1, 5'h04, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001, 20'hFFFE4, 8'd0};
    tbl[13] = '{1'b1, 5'h15, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b1111, 20'hAD6B5, 8'd0};
    tbl[14] = '{1'b0, 5'h0E, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 20'h00000, 8'd0};
    tbl[15] = '{1'b1, 5'h1E, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1000, 20'hF0000, 8'd0};

    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step4(tbl[i].r, tbl[i].d, tbl[i].s, tbl[i].bc, tbl[i].v, tbl[i].ordy);
      $display("tbl%0d: rdy=%b valid=%b data=%h err=%0d", i, rdy4_seen,
               b4.out_valid, b4.out_data, b4.err_cnt);
      check($sformatf("tbl%0d_ready", i), 32'(rdy4_seen), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_valid", i), 32'(b4.out_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_data", i), 32'(b4.out_data), 32'(tbl[i].e_data));
      check($sformatf("tbl%0d_err", i), 32'(b4.err_cnt), 32'(tbl[i].e_err));
    end

    // Random traffic on the 4-channel instance, occasional resets mixed in
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 49) != 0);
      d    = 5'($urandom);
      s    = 2'($urandom);
      bc   = ($urandom_range(0, 5) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = 4'($urandom);
      step4(r, d, s, bc, v, ordy);
      $display("rnd%0d: r=%b v=%b bc=%b s=%0d d=%h ordy=%b rdy=%b valid=%b data=%h",
               i, r, v, bc, s, d, ordy, rdy4_seen, b4.out_valid, b4.out_data);
      check($sformatf("rnd%0d_ready", i), 32'(rdy4_seen), 32'(mdl_rdy));
      check($sformatf("rnd%0d_valid", i), 32'(b4.out_valid), 32'(model_valid()));
      check($sformatf("rnd%0d_data", i), 32'(b4.out_data), 32'(model_data()));
      check($sformatf("rnd%0d_err", i), 32'(b4.err_cnt), 32'(merr));
    end
    step4(1'b1, 5'h00, 2'd0, 1'b0, 1'b0, 4'b0000);

    // Out-of-range flood on the 3-channel instance: counter saturates
    step3(1'b0, 5'h00, 2'd0, 1'b0, 1'b0, 3'b000);
    check("n3_reset_err", 32'(b3.err_cnt), 32'd0);
    bad_rdy = 0;
    bad_val = 0;
    for (int i = 0; i < 300; i++) begin
      step3(1'b1, 5'(i), 2'd3, 1'b0, 1'b1, 3'b000);
      if (rdy3_seen !== 1'b1) bad_rdy++;
      if (b3.out_valid !== 3'b000) bad_val++;
    end
    $display("oor300: bad_rdy=%0d bad_val=%0d err=%0d", bad_rdy, bad_val, b3.err_cnt);
    check("oor_ready_always", 32'(bad_rdy), 32'd0);
    check("oor_no_valid", 32'(bad_val), 32'd0);
    check("oor_err_sat", 32'(b3.err_cnt), 32'd255);

    // Mid-stream reset: all channels live and err_cnt at 9, then one reset cycle
    step3(1'b0, 5'h00, 2'd0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 9; i++) step3(1'b1, 5'h01, 2'd3, 1'b0, 1'b1, 3'b000);
    step3(1'b1, 5'h0C, 2'd0, 1'b1, 1'b1, 3'b000);
    $display("n3_fill: valid=%b data=%h err=%0d", b3.out_valid, b3.out_data, b3.err_cnt);
    check("n3_fill_valid", 32'(b3.out_valid), 32'b111);
    check("n3_fill_data", 32'(b3.out_data), 32'h318C);
    check("n3_fill_err", 32'(b3.err_cnt), 32'd9);
    step3(1'b0, 5'h1F, 2'd0, 1'b1, 1'b1, 3'b111);
    $display("n3_rst: rdy=%b valid=%b data=%h err=%0d", rdy3_seen, b3.out_valid,
             b3.out_data, b3.err_cnt);
    check("n3_rst_ready", 32'(rdy3_seen), 32'd0);
    check("n3_rst_valid", 32'(b3.out_valid), 32'd0);
    check("n3_rst_data", 32'(b3.out_data), 32'd0);
    check("n3_rst_err", 32'(b3.err_cnt), 32'd0);
    step3(1'b1, 5'h00, 2'd0, 1'b0, 1'b0, 3'b111);
    $display("n3_post: valid=%b data=%h", b3.out_valid, b3.out_data);
    check("n3_post_valid", 32'(b3.out_valid), 32'd0);
    check("n3_post_data", 32'(b3.out_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL provide parameter WIDTH, default 5, payload width in bits.
REQ-002 SHALL provide parameter N, default 4, number of output channels (2..16).
REQ-003 SHALL provide parameter SW, default 2, select width; 2**SW >= N is required, and elaboration SHALL fail otherwise.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-007 in_data  input  WIDTH  payload to route.
REQ-008 in_sel  input  SW  destination channel index.
REQ-009 in_bcast  input  1  1 = deliver to all N channels; in_sel ignored.
REQ-010 in_valid  input  1  upstream word present.
REQ-011 in_ready  output  1  block accepts word this cycle.
REQ-012 out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 out_valid  output  N  channel k holds an undelivered word.
REQ-014 out_ready  input  N  downstream k consumes the word this cycle.
REQ-015 err_cnt  output  8  count of words dropped for out-of-range select.

Function
REQ-016 Each channel SHALL have a one-entry holding register; a transfer occurs on a channel when out_valid[k] & out_ready[k].
REQ-017 Input transfer SHALL occur when in_valid & in_ready at a rising clk edge.
REQ-018 Latency SHALL be exactly 1 cycle: data accepted at edge t is visible on out_data/out_valid after edge t.
REQ-019 Channel k SHALL be free when out_valid[k]==0 or out_ready[k]==1 in the same cycle.
REQ-020 Unicast (in_bcast=0, in_sel<N): in_ready SHALL equal free[in_sel].
REQ-021 Broadcast (in_bcast=1): in_ready SHALL be 1 only when all N channels are free; on transfer all N registers load in_data and all out_valid set together; no partial delivery.
REQ-022 Out-of-range (in_bcast=0, in_sel>=N): in_ready SHALL be 1; word SHALL be discarded; err_cnt SHALL increment by 1, saturating at 255.
REQ-023 in_ready SHALL be combinational from in_sel, in_bcast, out_valid, out_ready; it SHALL NOT depend on in_valid.
REQ-024 Once out_valid[k] is 1, it and out_data[k] SHALL remain stable until the channel transfers.
REQ-025 Simultaneous drain and refill of channel k in one cycle: out_valid[k] SHALL stay 1 with the new data on the next cycle.
REQ-026 Drain without refill: out_valid[k] SHALL go to 0 on the next cycle; out_data[k] SHALL hold its last value.
REQ-027 Channels not selected SHALL keep their data and valid state unchanged except for their own drain.
REQ-028 Sustained throughput: a channel whose out_ready is held at 1 SHALL accept one word per cycle.
REQ-029 When in_valid==0, no register other than drain-driven out_valid clearing SHALL change.

Reset
REQ-030 While rst_n==0 at a clk edge, the block SHALL load out_valid=0, out_data=0, and err_cnt=0.
REQ-031 During reset, in_ready SHALL be 0, and no input SHALL be accepted in a cycle where rst_n==0.
REQ-032 Reset asserted mid-operation SHALL discard all held words with no output transfer afterwards.
REQ-033 The first transfer after reset SHALL be possible in the first cycle with rst_n==1.

Verification
REQ-034 Unicast: with N=4 and all out_ready=1, drive in_sel=2 and in_data=5'h07 for 1 cycle -> next cycle out_valid=4'b0100, channel 2 data=5'h07, other channels 0.
REQ-035 Backpressure: out_ready[1]=0; send 5'h11 then 5'h12 to channel 1 -> first accepted, in_ready=0 for the second; channel 1 holds 5'h11; raise out_ready[1] -> 5'h12 delivered the next cycle.
REQ-036 Broadcast: out_valid[3]=1 with out_ready[3]=0; in_bcast=1 and in_data=5'h1F -> in_ready=0 and no channel changes; release out_ready[3] -> all four channels show 5'h1F with out_valid=4'hF.
REQ-037 Out-of-range: N=3 and SW=2; send 300 words with in_sel=3 -> in_ready always 1, out_valid stays 0, err_cnt=255.
REQ-038 Drain and refill: channel 0 holds 5'h03 with out_ready[0]=1; send 5'h04 to channel 0 the same cycle -> next cycle out_valid[0]=1, data=5'h04, no bubble.
REQ-039 Reset mid-stream: all channels valid and err_cnt=9; pulse rst_n=0 for 1 cycle -> out_valid=0, out_data=0, err_cnt=0, and in_ready=0 during the reset cycle.
